// File: rtl/fp_sqrt_arbiter.sv
// Round-robin front end that shares one iterative fp_sqrt unit between N_REQ requesters.
// Each grant issues one start pulse, holds the operand until done or timeout, then returns the result.
module fp_sqrt_arbiter #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned FP_WIDTH  = 32,
    parameter int unsigned RES_WIDTH = 40,
    parameter int unsigned TIMEOUT   = 255,
    localparam int unsigned IdW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic [N_REQ*FP_WIDTH-1:0]   req_a_i,
    input  logic [N_REQ*3-1:0]          req_rnd_i,
    output logic                        sqrt_start_o,
    output logic [FP_WIDTH-1:0]         sqrt_a_o,
    output logic [2:0]                  sqrt_rnd_o,
    input  logic                        sqrt_done_i,
    input  logic [RES_WIDTH-1:0]        sqrt_res_i,
    output logic                        resp_valid_o,
    input  logic                        resp_ready_i,
    output logic [IdW-1:0]              resp_id_o,
    output logic [RES_WIDTH-1:0]        resp_res_o,
    output logic                        resp_err_o,
    output logic                        busy_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]           r_state;
    logic [IdW-1:0]       r_rr_ptr;
    logic [FP_WIDTH-1:0]  r_a;
    logic [2:0]           r_rnd;
    logic [IdW-1:0]       r_id;
    logic [RES_WIDTH-1:0] r_res;
    logic                 r_err;
    logic [CntW-1:0]      r_cnt;

    logic                 w_gnt_found;
    logic [IdW-1:0]       w_gnt_idx;
    logic [FP_WIDTH-1:0]  w_gnt_a;
    logic [2:0]           w_gnt_rnd;
    logic [CntW-1:0]      w_cnt_inc;

    // Search starts one past the last winner so the previous grantee has lowest priority.
    always_comb begin
        int unsigned w_idx;
        logic [IdW-1:0] w_sel;
        w_idx       = 0;
        w_sel       = '0;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_gnt_a     = '0;
        w_gnt_rnd   = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            w_idx = (32'(r_rr_ptr) + off) % N_REQ;
            w_sel = w_idx[IdW-1:0];
            if (!w_gnt_found && req_valid_i[w_sel]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_sel;
                w_gnt_a     = req_a_i[w_idx*FP_WIDTH +: FP_WIDTH];
                w_gnt_rnd   = req_rnd_i[w_idx*3 +: 3];
            end
        end
    end

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= IdW'(N_REQ - 1);
            r_a      <= '0;
            r_rnd    <= '0;
            r_id     <= '0;
            r_res    <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_found) begin
                        r_a      <= w_gnt_a;
                        r_rnd    <= w_gnt_rnd;
                        r_id     <= w_gnt_idx;
                        r_rr_ptr <= w_gnt_idx;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (sqrt_done_i) begin
                        r_res   <= sqrt_res_i;
                        r_err   <= 1'b0;
                        r_state <= ST_RESP;
                    end else if (w_cnt_inc == CntW'(TIMEOUT)) begin
                        r_res   <= '0;
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end
                end
                default: begin
                    if (resp_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (r_state == ST_IDLE && w_gnt_found) begin
            req_ready_o[w_gnt_idx] = 1'b1;
        end
    end

    // Operand stays on the bus until the cycle done is sampled; fp_sqrt reads it at that point.
    assign sqrt_start_o = (r_state == ST_ISSUE);
    assign sqrt_a_o     = (r_state == ST_ISSUE || r_state == ST_WAIT) ? r_a : '0;
    assign sqrt_rnd_o   = (r_state == ST_ISSUE || r_state == ST_WAIT) ? r_rnd : '0;

    assign resp_valid_o = (r_state == ST_RESP);
    assign resp_id_o    = (r_state == ST_RESP) ? r_id : '0;
    assign resp_res_o   = (r_state == ST_RESP) ? r_res : '0;
    assign resp_err_o   = (r_state == ST_RESP) ? r_err : 1'b0;
    assign busy_o       = (r_state != ST_IDLE);

endmodule
